pin_cmd_responder: RTL and testbench

//  Pin-side responder for the byte-wide command protocol the bench/host drives on the TT pins.

---
 rtl/pin_cmd_responder_pkg.sv | 23 ++
 rtl/pin_cmd_responder_sync_edge_det.sv | 28 ++
 rtl/pin_cmd_responder.sv | 149 ++++++++++++++
 tb/tb_pin_cmd_responder.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pin_cmd_responder_pkg.sv
// Shared types and constants for the pin-side command responder.
// Holds the FSM state enum, command field positions and the address wrap helper.
package pin_cmd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WDATA = 2'd1,
      RDATA = 2'd2
   } state_t;

   localparam int         CMD_RD_BIT = 7;
   localparam int         CMD_ADDR_W = 7;
   localparam logic [7:0] ERR_BYTE   = 8'hEE;

   // Next register address, wrapping from last back to zero.
   function automatic logic [CMD_ADDR_W-1:0] wrap_inc(
      input logic [CMD_ADDR_W-1:0] a,
      input logic [CMD_ADDR_W-1:0] last
   );
      return (a == last) ? '0 : a + 7'd1;
   endfunction

endpackage

// File: rtl/pin_cmd_responder_sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous toggle line plus edge pulse.
// Ports: clk, rst (async high), din (async toggle), pulse (1 cycle per din edge).
module sync_edge_det #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic pulse
);

   logic [STAGES-1:0] sh;
   logic              prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh   <= '0;
         prev <= 1'b0;
      end else begin
         sh   <= {sh[STAGES-2:0], din};
         prev <= sh[STAGES-1];
      end
   end

   // Either polarity of toggle counts as one event.
   assign pulse = sh[STAGES-1] ^ prev;

endmodule

// File: rtl/pin_cmd_responder.sv
// Byte-wide toggle-handshake command responder holding NREGS config registers.
// Ports: clk, rst, ena, req_tgl_i, frame_i, data_i[7:0] in; ack_tgl_o,
// data_o[7:0], busy_o, err_o, regs_o[NREGS*8-1:0] out.
// Build option PIN_CMD_AUTOINC_EN: burst reads/writes with address auto-increment.
module pin_cmd_responder
   import pin_cmd_pkg::*;
#(
   parameter int NREGS       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ena,
   input  logic               req_tgl_i,
   input  logic               frame_i,
   input  logic [7:0]         data_i,
   output logic               ack_tgl_o,
   output logic [7:0]         data_o,
   output logic               busy_o,
   output logic               err_o,
   output logic [NREGS*8-1:0] regs_o
);

   localparam int ADDR_W = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam logic [7:0] NREGS_B = 8'(NREGS);
   localparam logic [CMD_ADDR_W-1:0] LAST = CMD_ADDR_W'(NREGS - 1);

   state_t                  state;
   logic [CMD_ADDR_W-1:0]   addr;
   logic                    addr_ok;
   logic                    ack_pend;
   logic [7:0]              regs [NREGS];

   logic                    evt;
   logic [SYNC_STAGES-1:0]  frame_sh;
   logic                    frame_s;
   logic [CMD_ADDR_W-1:0]   cmd_addr;
   logic                    cmd_ok;
   logic                    is_cmd;

   sync_edge_det #(
      .STAGES(SYNC_STAGES)
   ) u_req_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (req_tgl_i),
      .pulse(evt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_sh <= '0;
      end else begin
         frame_sh <= {frame_sh[SYNC_STAGES-2:0], frame_i};
      end
   end

   assign frame_s  = frame_sh[SYNC_STAGES-1];
   assign cmd_addr = data_i[CMD_ADDR_W-1:0];
   assign cmd_ok   = {1'b0, cmd_addr} < NREGS_B;

`ifdef PIN_CMD_AUTOINC_EN
   logic [CMD_ADDR_W-1:0] addr_nxt;
   assign addr_nxt = wrap_inc(addr, LAST);
   assign is_cmd   = (state == IDLE);
`else
   // A byte arriving while a single read is finishing is a new command.
   assign is_cmd   = (state == IDLE) || (state == RDATA);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         busy_o    <= 1'b0;
         addr      <= '0;
         addr_ok   <= 1'b0;
         ack_pend  <= 1'b0;
         ack_tgl_o <= 1'b0;
         data_o    <= 8'h00;
         err_o     <= 1'b0;
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= 8'h00;
         end
      end else begin
         // Ack goes out one cycle after the byte was consumed.
         ack_tgl_o <= ack_tgl_o ^ ack_pend;
         ack_pend  <= 1'b0;
         if (!ena || !frame_s) begin
            state  <= IDLE;
            busy_o <= 1'b0;
         end else if (evt) begin
            ack_pend <= 1'b1;
            unique case (1'b1)
               is_cmd: begin
                  addr    <= cmd_addr;
                  addr_ok <= cmd_ok;
                  busy_o  <= 1'b1;
                  if (!cmd_ok) begin
                     err_o <= 1'b1;
                  end
                  if (data_i[CMD_RD_BIT]) begin
                     state  <= RDATA;
                     data_o <= cmd_ok ?
                               regs[cmd_addr[ADDR_W-1:0]] :
                               ERR_BYTE;
                  end else begin
                     state <= WDATA;
                  end
               end
               (state == WDATA): begin
                  if (addr_ok) begin
                     regs[addr[ADDR_W-1:0]] <= data_i;
                  end
`ifdef PIN_CMD_AUTOINC_EN
                  if (addr_ok) begin
                     addr <= addr_nxt;
                  end
`else
                  state  <= IDLE;
                  busy_o <= 1'b0;
`endif
               end
               default: begin
`ifdef PIN_CMD_AUTOINC_EN
                  // Burst read: data byte is a dummy, return next reg.
                  if (addr_ok) begin
                     addr   <= addr_nxt;
                     data_o <= regs[addr_nxt[ADDR_W-1:0]];
                  end else begin
                     data_o <= ERR_BYTE;
                  end
`endif
               end
            endcase
         end
`ifndef PIN_CMD_AUTOINC_EN
         else if (state == RDATA) begin
            state  <= IDLE;
            busy_o <= 1'b0;
         end
`endif
      end
   end

   for (genvar g = 0; g < NREGS; g++) begin : g_flat
      assign regs_o[8*g +: 8] = regs[g];
   end

endmodule

// File: tb/tb_pin_cmd_responder.sv
// Directed bench for pin_cmd_responder (NREGS=8, SYNC_STAGES=2).
// Covers both builds; PIN_CMD_AUTOINC_EN selects the burst scenario.
module tb_pin_cmd_responder;

   localparam int NREGS = 8;
   localparam int SS    = 2;
`ifdef PIN_CMD_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             ena;
   logic             req_tgl_i;
   logic             frame_i;
   logic [7:0]       data_i;
   logic             ack_tgl_o;
   logic [7:0]       data_o;
   logic             busy_o;
   logic             err_o;
   logic [NREGS*8-1:0] regs_o;

   int n_vec = 0;
   int n_err = 0;

   pin_cmd_responder #(
      .NREGS      (NREGS),
      .SYNC_STAGES(SS)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ena      (ena),
      .req_tgl_i(req_tgl_i),
      .frame_i  (frame_i),
      .data_i   (data_i),
      .ack_tgl_o(ack_tgl_o),
      .data_o   (data_o),
      .busy_o   (busy_o),
      .err_o    (err_o),
      .regs_o   (regs_o)
   );

   always #5 clk = ~clk;

   // Present a byte, flip req, watch 20 cycles for the ack edge.
   task automatic send(input logic [7:0] b, output bit got,
                       output int lat);
      logic a0;
      @(negedge clk);
      data_i    = b;
      a0        = ack_tgl_o;
      req_tgl_i = ~req_tgl_i;
      got = 1'b0;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (!got && ack_tgl_o !== a0) begin
            got = 1'b1;
            lat = i;
         end
      end
   endtask

   task automatic end_frame();
      @(negedge clk);
      frame_i = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      frame_i = 1'b1;
      repeat (5) @(posedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if (ack_tgl_o !== 1'b0) begin
         n_err++;
         $display("FAIL rst_ack got=%0b exp=0", ack_tgl_o);
      end
      n_vec++;
      if (data_o !== 8'h00) begin
         n_err++;
         $display("FAIL rst_data got=%h exp=00", data_o);
      end
      n_vec++;
      if (busy_o !== 1'b0) begin
         n_err++;
         $display("FAIL rst_busy got=%0b exp=0", busy_o);
      end
      n_vec++;
      if (err_o !== 1'b0) begin
         n_err++;
         $display("FAIL rst_err got=%0b exp=0", err_o);
      end
      n_vec++;
      if (regs_o !== '0) begin
         n_err++;
         $display("FAIL rst_regs got=%h exp=0", regs_o);
      end
      @(negedge clk);
      rst = 1'b0;
      frame_i = 1'b1;
      repeat (5) @(posedge clk);
   endtask

   task automatic test_write();
      bit got;
      int lat;
      send(8'h03, got, lat);
      n_vec++;
      if (got !== 1'b1 || lat != SS + 2) begin
         n_err++;
         $display("FAIL w_cmd_ack got=%0b lat=%0d exp=1 lat=%0d",
                  got, lat, SS + 2);
      end
      n_vec++;
      if (busy_o !== 1'b1) begin
         n_err++;
         $display("FAIL w_cmd_busy got=%0b exp=1", busy_o);
      end
      send(8'hA5, got, lat);
      n_vec++;
      if (got !== 1'b1) begin
         n_err++;
         $display("FAIL w_dat_ack got=%0b exp=1", got);
      end
      n_vec++;
      if (regs_o !== 64'h00000000_A5000000) begin
         n_err++;
         $display("FAIL w_regs got=%h exp=00000000a5000000", regs_o);
      end
      n_vec++;
      if (busy_o !== AUTOINC) begin
         n_err++;
         $display("FAIL w_busy got=%0b exp=%0b", busy_o, AUTOINC);
      end
      end_frame();
   endtask

   task automatic test_read();
      bit got;
      int lat;
      send(8'h83, got, lat);
      n_vec++;
      if (got !== 1'b1 || lat != SS + 2) begin
         n_err++;
         $display("FAIL r_ack got=%0b lat=%0d exp=1", got, lat);
      end
      n_vec++;
      if (data_o !== 8'hA5) begin
         n_err++;
         $display("FAIL r_data got=%h exp=a5", data_o);
      end
      n_vec++;
      if (err_o !== 1'b0) begin
         n_err++;
         $display("FAIL r_err got=%0b exp=0", err_o);
      end
      n_vec++;
      if (busy_o !== AUTOINC) begin
         n_err++;
         $display("FAIL r_busy got=%0b exp=%0b", busy_o, AUTOINC);
      end
      end_frame();
   endtask

   task automatic test_range_err();
      bit got;
      int lat;
      send(8'h8A, got, lat);
      n_vec++;
      if (got !== 1'b1 || data_o !== 8'hEE) begin
         n_err++;
         $display("FAIL oor_rd got=%0b/%h exp=1/ee", got, data_o);
      end
      n_vec++;
      if (err_o !== 1'b1) begin
         n_err++;
         $display("FAIL oor_err got=%0b exp=1", err_o);
      end
      end_frame();
      send(8'h0A, got, lat);
      send(8'h77, got, lat);
      n_vec++;
      if (got !== 1'b1 || regs_o !== 64'h00000000_A5000000) begin
         n_err++;
         $display("FAIL oor_wr got=%0b regs=%h exp=1 a5000000",
                  got, regs_o);
      end
      end_frame();
      send(8'h83, got, lat);
      n_vec++;
      if (data_o !== 8'hA5 || err_o !== 1'b1) begin
         n_err++;
         $display("FAIL oor_sticky got=%h/%0b exp=a5/1", data_o, err_o);
      end
      end_frame();
   endtask

   task automatic test_frame_drop();
      bit got;
      int lat;
      send(8'h05, got, lat);
      n_vec++;
      if (busy_o !== 1'b1) begin
         n_err++;
         $display("FAIL fd_busy got=%0b exp=1", busy_o);
      end
      @(negedge clk);
      frame_i = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      n_vec++;
      if (busy_o !== 1'b0) begin
         n_err++;
         $display("FAIL fd_idle got=%0b exp=0", busy_o);
      end
      send(8'h44, got, lat);
      n_vec++;
      if (got !== 1'b0) begin
         n_err++;
         $display("FAIL fd_noack got=%0b exp=0", got);
      end
      n_vec++;
      if (regs_o !== 64'h00000000_A5000000) begin
         n_err++;
         $display("FAIL fd_regs got=%h exp=a5000000", regs_o);
      end
      @(negedge clk);
      frame_i = 1'b1;
      repeat (5) @(posedge clk);
      send(8'h85, got, lat);
      n_vec++;
      if (got !== 1'b1 || data_o !== 8'h00) begin
         n_err++;
         $display("FAIL fd_rd5 got=%0b/%h exp=1/00", got, data_o);
      end
      end_frame();
   endtask

`ifdef PIN_CMD_AUTOINC_EN
   task automatic test_autoinc();
      bit got;
      int lat;
      send(8'h07, got, lat);
      send(8'h11, got, lat);
      send(8'h22, got, lat);
      n_vec++;
      if (got !== 1'b1 || regs_o !== 64'h11000000_A5000022) begin
         n_err++;
         $display("FAIL ai_wr got=%0b regs=%h exp=11000000a5000022",
                  got, regs_o);
      end
      end_frame();
      send(8'h87, got, lat);
      n_vec++;
      if (data_o !== 8'h11) begin
         n_err++;
         $display("FAIL ai_rd0 got=%h exp=11", data_o);
      end
      send(8'h5C, got, lat);
      n_vec++;
      if (got !== 1'b1 || data_o !== 8'h22) begin
         n_err++;
         $display("FAIL ai_rd1 got=%0b/%h exp=1/22", got, data_o);
      end
      n_vec++;
      if (busy_o !== 1'b1 || regs_o !== 64'h11000000_A5000022) begin
         n_err++;
         $display("FAIL ai_hold got=%0b/%h exp=1", busy_o, regs_o);
      end
      end_frame();
   endtask
`else
   task automatic test_single_cmd();
      bit got;
      int lat;
      send(8'h83, got, lat);
      n_vec++;
      if (data_o !== 8'hA5 || busy_o !== 1'b0) begin
         n_err++;
         $display("FAIL sc_rd got=%h/%0b exp=a5/0", data_o, busy_o);
      end
      send(8'h02, got, lat);
      n_vec++;
      if (got !== 1'b1 || busy_o !== 1'b1) begin
         n_err++;
         $display("FAIL sc_cmd got=%0b/%0b exp=1/1", got, busy_o);
      end
      send(8'h5A, got, lat);
      n_vec++;
      if (regs_o !== 64'h00000000_A55A0000 || busy_o !== 1'b0) begin
         n_err++;
         $display("FAIL sc_wr got=%h/%0b exp=a55a0000/0",
                  regs_o, busy_o);
      end
      end_frame();
   endtask
`endif

   task automatic test_ena();
      bit got;
      int lat;
      @(negedge clk);
      ena = 1'b0;
      send(8'h03, got, lat);
      n_vec++;
      if (got !== 1'b0 || busy_o !== 1'b0) begin
         n_err++;
         $display("FAIL ena_block got=%0b/%0b exp=0/0", got, busy_o);
      end
      @(negedge clk);
      ena = 1'b1;
      repeat (3) @(posedge clk);
      send(8'h83, got, lat);
      n_vec++;
      if (got !== 1'b1 || data_o !== 8'hA5) begin
         n_err++;
         $display("FAIL ena_back got=%0b/%h exp=1/a5", got, data_o);
      end
      end_frame();
   endtask

   task automatic test_rst_mid();
      bit got;
      int lat;
      send(8'h06, got, lat);
      n_vec++;
      if (busy_o !== 1'b1) begin
         n_err++;
         $display("FAIL rm_busy got=%0b exp=1", busy_o);
      end
      @(negedge clk);
      rst       = 1'b1;
      req_tgl_i = 1'b0;
      #1;
      n_vec++;
      if (busy_o !== 1'b0 || err_o !== 1'b0 || data_o !== 8'h00) begin
         n_err++;
         $display("FAIL rm_out got=%0b/%0b/%h exp=0/0/00",
                  busy_o, err_o, data_o);
      end
      n_vec++;
      if (regs_o !== '0 || ack_tgl_o !== 1'b0) begin
         n_err++;
         $display("FAIL rm_regs got=%h/%0b exp=0/0", regs_o, ack_tgl_o);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      n_vec++;
      if (busy_o !== 1'b0 || ack_tgl_o !== 1'b0) begin
         n_err++;
         $display("FAIL rm_quiet got=%0b/%0b exp=0/0", busy_o, ack_tgl_o);
      end
   endtask

   initial begin
      rst       = 1'b1;
      ena       = 1'b1;
      req_tgl_i = 1'b0;
      frame_i   = 1'b0;
      data_i    = 8'h00;
      test_reset();
      test_write();
      test_read();
      test_range_err();
      test_frame_drop();
`ifdef PIN_CMD_AUTOINC_EN
      test_autoinc();
`else
      test_single_cmd();
`endif
      test_ena();
      test_rst_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
